// File: rtl/step_driver_pkg.sv
// Shared encodings for the step_driver stimulus sequencer.
package step_driver_pkg;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_STEP   = 2'b01,
    MODE_RUN    = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/step_driver_tick_div.sv
// Free-running auto-step divider: one tick every 2^DIV_W enabled cycles.
// The count is held at 0 while disabled, so the first enabled cycle ticks.
module tick_div #(
  parameter int DIV_W = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  logic [DIV_W-1:0] div_q;

  // Count while enabled, park at zero otherwise.
  always_ff @(posedge clk) begin
    if (rst || !en) div_q <= '0;
    else            div_q <= div_q + DIV_W'(1);
  end

  assign tick = en && (div_q == '0);

endmodule

// File: rtl/step_driver.sv
// Request/acknowledge stimulus sequencer between board controls and a
// compute block.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | no request outstanding; waits for the mode trigger
// ST_ISSUE | single cycle with dut_req high and dut_arg valid
// ST_WAIT  | request outstanding; waits for dut_ack or timeout
module step_driver
  import step_driver_pkg::*;
#(
  parameter int W       = 16,
  parameter int IDX_W   = 5,
  parameter int MAX_IDX = 24,
  parameter int DIV_W   = 27,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [IDX_W-1:0] sel,
  output logic             dut_req,
  output logic [W-1:0]     dut_arg,
  input  logic             dut_ack,
  input  logic [W-1:0]     dut_res,
  output logic [W-1:0]     result,
  output logic             result_valid,
  output logic             busy,
  output logic             timeout
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] MAX_SEL  = IDX_W'(MAX_IDX);
  localparam logic [CNT_W-1:0] WAIT_TC  = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  mode_e            mode_v;
  logic [IDX_W-1:0] idx_q, idx_d, idx_inc;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             div_en, tick;
  logic             launch, ack_seen, abandon;

  assign mode_v  = mode_e'(mode);
  assign div_en  = (mode_v == MODE_STEP);
  assign idx_inc = (idx_q == MAX_SEL) ? '0 : idx_q + IDX_W'(1);
  assign dut_arg = W'(idx_q);

  tick_div #(.DIV_W(DIV_W)) u_tick_div (
    .clk  (clk),
    .rst  (rst),
    .en   (div_en),
    .tick (tick)
  );

  // Next-state, index update and event strobes.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    launch   = 1'b0;
    ack_seen = 1'b0;
    abandon  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        case (mode_v)
          MODE_MANUAL: begin
            if (sel != idx_q && sel <= MAX_SEL) begin
              idx_d  = sel;
              launch = 1'b1;
            end
          end
          MODE_STEP: begin
            // A tick while busy never reaches here, so it is simply lost.
            if (tick) begin
              idx_d  = idx_inc;
              launch = 1'b1;
            end
          end
          MODE_RUN: begin
            idx_d  = idx_inc;
            launch = 1'b1;
          end
          default: ;
        endcase
        if (launch) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (dut_ack) begin
          ack_seen = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (dut_ack) begin
          ack_seen = 1'b1;
          state_d  = ST_IDLE;
        end else if (wait_cnt_q == WAIT_TC) begin
          abandon  = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, index and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      dut_req      <= 1'b0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dut_req <= (state_d == ST_ISSUE);
      busy    <= (state_d != ST_IDLE);
      if (launch) result_valid <= 1'b0;
      if (ack_seen) begin
        result       <= dut_res;
        result_valid <= 1'b1;
      end
      if (abandon) timeout <= 1'b1;
    end
  end

  // Outstanding-request age; runs from the ISSUE cycle and saturates.
  always_ff @(posedge clk) begin
    if (rst || launch)
      wait_cnt_q <= '0;
    else if (state_q != ST_IDLE && wait_cnt_q != '1)
      wait_cnt_q <= wait_cnt_q + CNT_W'(1);
  end

endmodule

// File: tb/tb_step_driver.sv
// Directed bench for step_driver with a model block that answers arg*2.
module tb_step_driver;

  localparam int W       = 16;
  localparam int IDX_W   = 5;
  localparam int MAX_IDX = 24;
  localparam int DIV_W   = 3;
  localparam int TIMEOUT = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       mode;
  logic [IDX_W-1:0] sel;
  logic             dut_req;
  logic [W-1:0]     dut_arg;
  logic             dut_ack;
  logic [W-1:0]     dut_res;
  logic [W-1:0]     result;
  logic             result_valid;
  logic             busy;
  logic             timeout;

  int n_total = 0;
  int n_pass  = 0;

  // model block state
  int          ack_lat = 2;
  logic        ack_en  = 1'b1;
  int          pend    = 0;
  logic [W-1:0] arg_lat = '0;

  step_driver #(
    .W(W), .IDX_W(IDX_W), .MAX_IDX(MAX_IDX), .DIV_W(DIV_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mode         (mode),
    .sel          (sel),
    .dut_req      (dut_req),
    .dut_arg      (dut_arg),
    .dut_ack      (dut_ack),
    .dut_res      (dut_res),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  // Model block: acks ack_lat cycles after the request cycle.
  initial begin
    dut_ack = 1'b0;
    dut_res = '0;
    forever begin
      @(negedge clk);
      dut_ack = 1'b0;
      if (pend > 0) begin
        pend = pend - 1;
        if (pend == 0) begin
          dut_ack = ack_en;
          dut_res = W'(arg_lat * 2);
        end
      end
      if (dut_req === 1'b1) begin
        pend    = ack_lat;
        arg_lat = dut_arg;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    cyc();
    n = 0;
    while (busy && n < 30) begin
      cyc();
      n++;
    end
    check({name, " idle"}, 32'(busy), 0);
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [4:0]  sel;
    logic        req;
    logic [15:0] arg;
    logic        busy;
    logic        rv;
    logic [15:0] res;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int req_at[3];
    int req_arg[3];
    int nreq;
    int viol;
    logic prev_busy;
    int to_at;

    vecs[0]  = '{2'd0, 5'd5,  1'b1, 16'd5,  1'b1, 1'b0, 16'd0};
    vecs[1]  = '{2'd0, 5'd5,  1'b0, 16'd5,  1'b1, 1'b0, 16'd0};
    vecs[2]  = '{2'd0, 5'd5,  1'b0, 16'd5,  1'b1, 1'b0, 16'd0};
    vecs[3]  = '{2'd0, 5'd5,  1'b0, 16'd5,  1'b0, 1'b1, 16'd10};
    vecs[4]  = '{2'd0, 5'd5,  1'b0, 16'd5,  1'b0, 1'b1, 16'd10};
    vecs[5]  = '{2'd0, 5'd30, 1'b0, 16'd5,  1'b0, 1'b1, 16'd10};
    vecs[6]  = '{2'd0, 5'd31, 1'b0, 16'd5,  1'b0, 1'b1, 16'd10};
    vecs[7]  = '{2'd0, 5'd24, 1'b1, 16'd24, 1'b1, 1'b0, 16'd10};
    vecs[8]  = '{2'd0, 5'd3,  1'b0, 16'd24, 1'b1, 1'b0, 16'd10};
    vecs[9]  = '{2'd0, 5'd3,  1'b0, 16'd24, 1'b1, 1'b0, 16'd10};
    vecs[10] = '{2'd0, 5'd3,  1'b0, 16'd24, 1'b0, 1'b1, 16'd48};
    vecs[11] = '{2'd0, 5'd3,  1'b1, 16'd3,  1'b1, 1'b0, 16'd48};
    vecs[12] = '{2'd0, 5'd3,  1'b0, 16'd3,  1'b1, 1'b0, 16'd48};
    vecs[13] = '{2'd0, 5'd3,  1'b0, 16'd3,  1'b1, 1'b0, 16'd48};
    vecs[14] = '{2'd0, 5'd3,  1'b0, 16'd3,  1'b0, 1'b1, 16'd6};
    vecs[15] = '{2'd3, 5'd9,  1'b0, 16'd3,  1'b0, 1'b1, 16'd6};

    // reset
    rst = 1'b1; mode = 2'd3; sel = '0;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    check("rst dut_req", 32'(dut_req), 0);
    check("rst dut_arg", 32'(dut_arg), 0);
    check("rst result", 32'(result), 0);
    check("rst result_valid", 32'(result_valid), 0);
    check("rst busy", 32'(busy), 0);
    check("rst timeout", 32'(timeout), 0);

    // manual mode vector table
    for (int i = 0; i < 16; i++) begin
      mode = vecs[i].mode;
      sel  = vecs[i].sel;
      cyc();
      check($sformatf("vec%0d dut_req", i), 32'(dut_req), 32'(vecs[i].req));
      check($sformatf("vec%0d dut_arg", i), 32'(dut_arg), 32'(vecs[i].arg));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d result_valid", i), 32'(result_valid), 32'(vecs[i].rv));
      check($sformatf("vec%0d result", i), 32'(result), 32'(vecs[i].res));
    end

    // auto-step wrap from index 23
    mode = 2'd0; sel = 5'd23;
    wait_idle("load23");
    check("load23 result", 32'(result), 46);
    mode = 2'd1;
    nreq = 0;
    for (int i = 0; i < 3; i++) begin req_at[i] = -1; req_arg[i] = -1; end
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (dut_req && nreq < 3) begin
        req_at[nreq]  = k;
        req_arg[nreq] = int'(dut_arg);
        nreq++;
      end
    end
    check("step req0 cycle", 32'(req_at[0]), 1);
    check("step req0 arg", 32'(req_arg[0]), 24);
    check("step req1 cycle", 32'(req_at[1]), 9);
    check("step req1 arg", 32'(req_arg[1]), 0);
    check("step req2 cycle", 32'(req_at[2]), 17);
    check("step req2 arg", 32'(req_arg[2]), 1);

    // auto-run from index 10
    mode = 2'd0; sel = 5'd10;
    wait_idle("load10");
    check("load10 result", 32'(result), 20);
    mode = 2'd2;
    nreq = 0; viol = 0; prev_busy = busy;
    for (int i = 0; i < 3; i++) begin req_at[i] = -1; req_arg[i] = -1; end
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (dut_req && prev_busy) viol++;
      prev_busy = busy;
      if (dut_req) begin
        if (nreq < 3) begin
          req_at[nreq]  = k;
          req_arg[nreq] = int'(dut_arg);
        end
        nreq++;
      end
    end
    mode = 2'd3;
    check("run req count", 32'(nreq), 3);
    check("run req while busy", 32'(viol), 0);
    check("run req0 cycle", 32'(req_at[0]), 1);
    check("run req0 arg", 32'(req_arg[0]), 11);
    check("run req1 cycle", 32'(req_at[1]), 5);
    check("run req1 arg", 32'(req_arg[1]), 12);
    check("run req2 cycle", 32'(req_at[2]), 9);
    check("run req2 arg", 32'(req_arg[2]), 13);
    wait_idle("run drain");

    // timeout: block never answers
    ack_en = 1'b0;
    mode = 2'd0; sel = 5'd7;
    cyc();
    check("to issue req", 32'(dut_req), 1);
    check("to issue arg", 32'(dut_arg), 7);
    to_at = -1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (timeout && to_at < 0) to_at = k;
      if (to_at >= 0) break;
    end
    check("to cycles after issue", 32'(to_at), 8);
    check("to busy", 32'(busy), 0);
    check("to result_valid", 32'(result_valid), 0);
    ack_en = 1'b1;
    sel = 5'd8;
    wait_idle("after to");
    check("after to result", 32'(result), 16);
    check("after to result_valid", 32'(result_valid), 1);
    check("timeout sticky", 32'(timeout), 1);

    // reset during WAIT, ack arrives the cycle after
    sel = 5'd9;
    cyc();
    check("rw issue req", 32'(dut_req), 1);
    mode = 2'd3;
    cyc();
    check("rw in wait busy", 32'(busy), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    check("rw result", 32'(result), 0);
    check("rw result_valid", 32'(result_valid), 0);
    check("rw busy", 32'(busy), 0);
    check("rw timeout", 32'(timeout), 0);
    check("rw dut_arg", 32'(dut_arg), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
